blit_phrase_pipe: RTL and testbench

- Parametrised next-generation blitter data path: aligns source phrases with a two-phrase funnel shifter and combines them with destination data through the 4-bit logic function unit (LFU).
- Applies per-lane pattern compare and start/end masking, then emits a write phrase with byte enables.
- Sits between the blitter read-data return and the memory write port. Replaces the fixed 64-bit data unit with a width-generic, handshaked two-stage pipeline.

---
 rtl/blit_phrase_pipe.sv | 175 +++++++++++++++++
 tb/tb_blit_phrase_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_phrase_pipe.sv
// Width-generic blitter phrase data path: funnel-aligns source, combines with destination
// through the LFU, applies pattern compare and lane masking. Optional saturating lane add: BLIT_PHRASE_ADD_EN.
module blit_phrase_pipe #(
    parameter int PHRASE_W = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_ld,
    input  logic [3:0]                    cfg_lfu,
    input  logic [PHRASE_W-1:0]           cfg_pattern,
    input  logic                          cfg_patsel,
    input  logic                          cfg_cmpdst,
    input  logic                          cfg_dcompen,
    input  logic                          cfg_add,
    input  logic [$clog2(PHRASE_W)-1:0]   cfg_srcshift,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic [PHRASE_W-1:0]           in_src,
    input  logic [PHRASE_W-1:0]           in_dst,
    input  logic [$clog2(PHRASE_W/8):0]   in_dstart,
    input  logic [$clog2(PHRASE_W/8):0]   in_dend,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PHRASE_W-1:0]           out_data,
    output logic [PHRASE_W/8-1:0]         out_be,
    output logic [PHRASE_W/8-1:0]         out_dcomp
);

    localparam int LANES = PHRASE_W / 8;
    localparam int SHW   = $clog2(PHRASE_W);
    localparam int LW    = $clog2(LANES) + 1;

    logic [3:0]          r_cfg_lfu;
    logic [PHRASE_W-1:0] r_cfg_pattern;
    logic                r_cfg_patsel;
    logic                r_cfg_cmpdst;
    logic                r_cfg_dcompen;
    logic                r_cfg_add;
    logic [SHW-1:0]      r_cfg_srcshift;

    logic [PHRASE_W-1:0] r_srcd1;
    logic                r_s0_valid;
    logic [PHRASE_W-1:0] r_s0_aligned;
    logic [PHRASE_W-1:0] r_s0_dst;
    logic [LW-1:0]       r_s0_dstart;
    logic [LW-1:0]       r_s0_dend;

    logic                r_out_valid;
    logic [PHRASE_W-1:0] r_out_data;
    logic [LANES-1:0]    r_out_be;
    logic [LANES-1:0]    r_out_dcomp;

    logic                w_s1_adv;
    logic                w_s0_adv;
    logic                w_accept;
    logic [PHRASE_W-1:0] w_aligned;
    logic [PHRASE_W-1:0] w_s;
    logic [PHRASE_W-1:0] w_d;
    logic [PHRASE_W-1:0] w_lfu;
    logic [PHRASE_W-1:0] w_result;
    logic [PHRASE_W-1:0] w_cmp;
    logic [LW-1:0]       w_dend_eff;
    logic [LANES-1:0]    w_dcomp;
    logic [LANES-1:0]    w_be;

    // Handshake: a beat moves on in_valid & in_ready, a result on out_valid & out_ready;
    // stage 1 refills whenever the output is empty or draining, stage 0 whenever stage 1 moves.
    assign w_s1_adv = !r_out_valid || out_ready;
    assign w_s0_adv = !r_s0_valid || w_s1_adv;
    assign in_ready = w_s0_adv && !reset;
    assign w_accept = in_valid && in_ready;
    assign busy     = r_s0_valid || r_out_valid;

    // Previous phrase sits in the upper half so a zero shift passes the current source through.
    assign w_aligned = PHRASE_W'({r_srcd1, in_src} >> r_cfg_srcshift);

    assign w_s   = r_cfg_patsel ? r_cfg_pattern : r_s0_aligned;
    assign w_d   = r_s0_dst;
    assign w_lfu = ({PHRASE_W{r_cfg_lfu[0]}} & ~w_s & ~w_d)
                 | ({PHRASE_W{r_cfg_lfu[1]}} & ~w_s &  w_d)
                 | ({PHRASE_W{r_cfg_lfu[2]}} &  w_s & ~w_d)
                 | ({PHRASE_W{r_cfg_lfu[3]}} &  w_s &  w_d);

`ifdef BLIT_PHRASE_ADD_EN
    logic [PHRASE_W-1:0] w_sum;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] v_t;
        v_t = {1'b0, a} + {1'b0, b};
        return v_t[8] ? 8'hFF : v_t[7:0];
    endfunction

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum[8*i +: 8] = sat_add8(w_s[8*i +: 8], w_d[8*i +: 8]);
        end
    end

    assign w_result = r_cfg_add ? w_sum : w_lfu;
`else
    logic w_unused_cfg_add;
    assign w_unused_cfg_add = r_cfg_add;
    assign w_result         = w_lfu;
`endif

    always_comb begin
        w_cmp      = r_cfg_cmpdst ? w_d : r_s0_aligned;
        w_dend_eff = (r_s0_dend == '0) ? LW'(LANES) : r_s0_dend;
        w_dcomp    = '0;
        w_be       = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dcomp[i] = (w_cmp[8*i +: 8] == r_cfg_pattern[8*i +: 8]);
            w_be[i]    = (LW'(i) >= r_s0_dstart) && (LW'(i) < w_dend_eff)
                         && !(r_cfg_dcompen && w_dcomp[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_lfu      <= '0;
            r_cfg_pattern  <= '0;
            r_cfg_patsel   <= 1'b0;
            r_cfg_cmpdst   <= 1'b0;
            r_cfg_dcompen  <= 1'b0;
            r_cfg_add      <= 1'b0;
            r_cfg_srcshift <= '0;
            r_srcd1        <= '0;
            r_s0_valid     <= 1'b0;
            r_s0_aligned   <= '0;
            r_s0_dst       <= '0;
            r_s0_dstart    <= '0;
            r_s0_dend      <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_be       <= '0;
            r_out_dcomp    <= '0;
        end else begin
            if (cfg_ld && !busy) begin
                r_cfg_lfu      <= cfg_lfu;
                r_cfg_pattern  <= cfg_pattern;
                r_cfg_patsel   <= cfg_patsel;
                r_cfg_cmpdst   <= cfg_cmpdst;
                r_cfg_dcompen  <= cfg_dcompen;
                r_cfg_add      <= cfg_add;
                r_cfg_srcshift <= cfg_srcshift;
            end
            if (w_accept) begin
                r_srcd1      <= in_src;
                r_s0_aligned <= w_aligned;
                r_s0_dst     <= in_dst;
                r_s0_dstart  <= in_dstart;
                r_s0_dend    <= in_dend;
            end
            // A prime beat only refreshes the previous-source register.
            if (w_s0_adv) begin
                r_s0_valid <= in_valid && !in_first;
            end
            if (w_s1_adv) begin
                r_out_valid <= r_s0_valid;
                r_out_data  <= w_result;
                r_out_be    <= w_be;
                r_out_dcomp <= w_dcomp;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_be    = r_out_be;
    assign out_dcomp = r_out_dcomp;

endmodule

// File: tb/tb_blit_phrase_pipe.sv
// Directed bench for blit_phrase_pipe at PHRASE_W=64: reset, LFU, funnel shift, masking,
// pattern compare, stall hold, config-ignore while busy and mid-flight reset.
module tb_blit_phrase_pipe;

  localparam int PHRASE_W = 64;
  localparam int LANES    = PHRASE_W / 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cfg_ld = 1'b0;
  logic [3:0]          cfg_lfu = '0;
  logic [PHRASE_W-1:0] cfg_pattern = '0;
  logic                cfg_patsel = 1'b0;
  logic                cfg_cmpdst = 1'b0;
  logic                cfg_dcompen = 1'b0;
  logic                cfg_add = 1'b0;
  logic [5:0]          cfg_srcshift = '0;
  logic                busy;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_first = 1'b0;
  logic [PHRASE_W-1:0] in_src = '0;
  logic [PHRASE_W-1:0] in_dst = '0;
  logic [3:0]          in_dstart = '0;
  logic [3:0]          in_dend = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [PHRASE_W-1:0] out_data;
  logic [LANES-1:0]    out_be;
  logic [LANES-1:0]    out_dcomp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PHRASE_W-1:0] exp_q[$];

  blit_phrase_pipe #(.PHRASE_W(PHRASE_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_ld(cfg_ld), .cfg_lfu(cfg_lfu), .cfg_pattern(cfg_pattern),
    .cfg_patsel(cfg_patsel), .cfg_cmpdst(cfg_cmpdst), .cfg_dcompen(cfg_dcompen),
    .cfg_add(cfg_add), .cfg_srcshift(cfg_srcshift), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_src(in_src), .in_dst(in_dst), .in_dstart(in_dstart), .in_dend(in_dend),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .out_dcomp(out_dcomp)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_cfg(input logic [3:0] lfu, input logic [63:0] pat, input logic patsel,
                        input logic cmpdst, input logic dcompen, input logic [5:0] shift);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("cfg_idle", 64'(busy), 64'd0);
    cfg_lfu      = lfu;
    cfg_pattern  = pat;
    cfg_patsel   = patsel;
    cfg_cmpdst   = cmpdst;
    cfg_dcompen  = dcompen;
    cfg_srcshift = shift;
    cfg_ld       = 1'b1;
    @(posedge clk);
    #1 cfg_ld = 1'b0;
  endtask

  task automatic send_beat(input logic first, input logic [63:0] src, input logic [63:0] dst,
                           input logic [3:0] dstart, input logic [3:0] dend);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_first  = first;
    in_src    = src;
    in_dst    = dst;
    in_dstart = dstart;
    in_dend   = dend;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("in_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] data,
                            input logic [7:0] be, input logic [7:0] dcomp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_data"}, out_data, data);
    check_eq({tag, "_be"}, 64'(out_be), 64'(be));
    check_eq({tag, "_dcomp"}, 64'(out_dcomp), 64'(dcomp));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check_eq(tag, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int got;
    int guard;
    logic drop;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_be", 64'(out_be), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // copy source (minterms S&D, S&!D), shift 0, full lanes, with latency check
    do_cfg(4'b1100, 64'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    send_beat(1'b0, 64'h0123456789ABCDEF, 64'h0, 4'd0, 4'd0);
    @(negedge clk);
    check_eq("lat_stage0_only", 64'(out_valid), 64'd0);
    check_eq("lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check_eq("lat_out_valid", 64'(out_valid), 64'd1);
    check_eq("copy_data", out_data, 64'h0123456789ABCDEF);
    check_eq("copy_be", 64'(out_be), 64'hFF);
    check_eq("copy_dcomp", 64'(out_dcomp), 64'h00);
    @(posedge clk);
    #1;
    expect_idle("copy_drained");

    // minterms !S&D, S&D select destination
    do_cfg(4'b1010, 64'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    send_beat(1'b0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'd0, 4'd0);
    expect_out("lfu_d", 64'hFEDCBA9876543210, 8'hFF, 8'h00);

    // prime beat then shifted beat
    do_cfg(4'b1100, 64'h0, 1'b0, 1'b0, 1'b0, 6'd8);
    send_beat(1'b1, 64'h1111111111111111, 64'h0, 4'd0, 4'd0);
    send_beat(1'b0, 64'h2222222222222222, 64'h0, 4'd0, 4'd0);
    expect_out("funnel", 64'h1122222222222222, 8'hFF, 8'h00);
    expect_idle("funnel_no_extra");

    // XOR with partial lane window
    do_cfg(4'b0110, 64'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    send_beat(1'b0, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 4'd2, 4'd6);
    expect_out("xor", 64'hF00FF00FF00FF00F, 8'b00111100, 8'h55);

    // destination compare inhibits write on equal lanes
    do_cfg(4'b1100, 64'h0, 1'b0, 1'b1, 1'b1, 6'd0);
    send_beat(1'b0, 64'h1234567890ABCDEF, 64'h00AABBCCDDEEFF00, 4'd0, 4'd0);
    expect_out("dcompen", 64'h1234567890ABCDEF, 8'h7E, 8'h81);

    // pattern as source; empty window and last-lane-only window
    do_cfg(4'b1100, 64'h5A5A5A5A5A5A5A5A, 1'b1, 1'b0, 1'b0, 6'd0);
    send_beat(1'b0, 64'h5A5A5A5A00000000, 64'hFFFFFFFFFFFFFFFF, 4'd5, 4'd3);
    send_beat(1'b0, 64'h5A5A5A5A00000000, 64'hFFFFFFFFFFFFFFFF, 4'd7, 4'd0);
    expect_out("pat_empty", 64'h5A5A5A5A5A5A5A5A, 8'h00, 8'hF0);
    expect_out("pat_last", 64'h5A5A5A5A5A5A5A5A, 8'h80, 8'hF0);

    // stall: two beats buffer, third waits; cfg_ld while busy is ignored
    do_cfg(4'b1100, 64'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    out_ready = 1'b0;
    send_beat(1'b0, 64'hAAAA0000AAAA0001, 64'h0, 4'd0, 4'd0);
    send_beat(1'b0, 64'hAAAA0000AAAA0002, 64'h0, 4'd0, 4'd0);
    exp_q.push_back(64'hAAAA0000AAAA0001);
    exp_q.push_back(64'hAAAA0000AAAA0002);
    exp_q.push_back(64'hAAAA0000AAAA0003);
    in_valid = 1'b1;
    in_src   = 64'hAAAA0000AAAA0003;
    in_dst   = 64'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("stall_out_valid", 64'(out_valid), 64'd1);
      check_eq("stall_out_data", out_data, 64'hAAAA0000AAAA0001);
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      cfg_lfu = 4'b0000;
      cfg_ld  = (k == 1);
    end
    cfg_ld = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    got   = 0;
    guard = 0;
    while (got < 3 && guard < 30) begin
      @(negedge clk);
      if (out_valid) begin
        check_eq("drain_order", out_data, exp_q.pop_front());
        got++;
      end
      drop = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (drop) in_valid = 1'b0;
      guard++;
    end
    check_eq("drain_count", 64'(got), 64'd3);
    check_eq("drain_in_consumed", 64'(in_valid), 64'd0);
    expect_idle("drain_no_extra");

    // reset with a beat in flight clears pipeline and previous source
    send_beat(1'b0, 64'h4444444444444444, 64'h0, 4'd0, 4'd0);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    do_cfg(4'b1100, 64'h0, 1'b0, 1'b0, 1'b0, 6'd8);
    send_beat(1'b0, 64'h3333333333333333, 64'h0, 4'd0, 4'd0);
    expect_out("post_rst_funnel", 64'h0033333333333333, 8'hFF, 8'h80);
    expect_idle("post_rst_no_extra");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
